// File: rtl/conv_relu_pool.sv
// Post-convolution stage: bias, ReLU, rounded requantisation with saturation and 2x2 max-pool.
// Captures one 4x4 tile per conv_done rising edge and streams four pooled int8 beats.
module conv_relu_pool #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    conv_done,
  input  logic signed [IN_W-1:0]  c_in [0:3][0:3],
  input  logic signed [IN_W-1:0]  bias,
  input  logic        [3:0]       shift,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    drop_err
);

  // Two extra bits: one so c + bias cannot wrap, one so the rounding add cannot either.
  localparam int unsigned SW = IN_W + 2;
  localparam logic [SW-1:0] SatVal = SW'((1 << (OUT_W - 1)) - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StProc   = 2'd1;
  localparam logic [1:0] StStream = 2'd2;

  logic [1:0]             state_q, state_d;
  logic                   done_q;
  logic [1:0]             k_q, k_d;
  logic [1:0]             idx_q, idx_d;
  logic                   drop_err_q, drop_err_d;
  logic signed [IN_W-1:0] tile_q [0:3][0:3];
  logic signed [IN_W-1:0] bias_q;
  logic [3:0]             shift_q;
  logic [OUT_W-1:0]       res_q [0:3];

  logic                   cap_evt;
  logic                   load_tile;
  logic                   res_we;
  logic [OUT_W-1:0]       win_max;

  assign cap_evt = conv_done && !done_q;

  function automatic logic [OUT_W-1:0] requant(input logic signed [IN_W-1:0] c,
                                              input logic signed [IN_W-1:0] b,
                                              input logic [3:0] sh);
    logic signed [SW-1:0] s;
    logic [SW-1:0]        r;
    logic [SW-1:0]        q;
    s = {{2{c[IN_W-1]}}, c} + {{2{b[IN_W-1]}}, b};
    r = s[SW-1] ? '0 : $unsigned(s);
    // Half-LSB rounding term; shifting 1<<sh down by one yields zero when sh is zero.
    r = r + ((SW'(1) << sh) >> 1);
    q = r >> sh;
    return (q > SatVal) ? SatVal[OUT_W-1:0] : q[OUT_W-1:0];
  endfunction

  // Window k covers rows {k[1],x} and cols {k[0],x}.
  always_comb begin
    logic [1:0]       ri;
    logic [1:0]       ci;
    logic [OUT_W-1:0] y;
    win_max = '0;
    ri      = '0;
    ci      = '0;
    y       = '0;
    for (int dr = 0; dr < 2; dr++) begin
      for (int dc = 0; dc < 2; dc++) begin
        ri = {k_q[1], 1'(dr)};
        ci = {k_q[0], 1'(dc)};
        y  = requant(tile_q[ri][ci], bias_q, shift_q);
        if (y > win_max) win_max = y;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    idx_d      = idx_q;
    drop_err_d = drop_err_q;
    load_tile  = 1'b0;
    res_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cap_evt) begin
          load_tile = 1'b1;
          k_d       = '0;
          state_d   = StProc;
        end
      end
      StProc: begin
        res_we = 1'b1;
        k_d    = k_q + 2'd1;
        if (cap_evt) drop_err_d = 1'b1;
        if (k_q == 2'd3) begin
          idx_d   = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        if (cap_evt) drop_err_d = 1'b1;
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      done_q     <= 1'b0;
      k_q        <= '0;
      idx_q      <= '0;
      drop_err_q <= 1'b0;
      bias_q     <= '0;
      shift_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        res_q[i] <= '0;
        for (int j = 0; j < 4; j++) tile_q[i][j] <= '0;
      end
    end else begin
      state_q    <= state_d;
      done_q     <= conv_done;
      k_q        <= k_d;
      idx_q      <= idx_d;
      drop_err_q <= drop_err_d;
      if (load_tile) begin
        bias_q  <= bias;
        shift_q <= shift;
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) tile_q[i][j] <= c_in[i][j];
        end
      end
      if (res_we) res_q[k_q] <= win_max;
    end
  end

  assign out_valid = (state_q == StStream);
  assign out_last  = out_valid && (idx_q == 2'd3);
  assign out_data  = out_valid ? res_q[idx_q] : '0;
  assign busy      = (state_q != StIdle);
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_conv_relu_pool.sv
// Self-checking bench for conv_relu_pool: directed vectors plus randomized tiles
// checked against an arithmetic model of bias/ReLU/requant/pool.
module tb_conv_relu_pool;

  logic              clk;
  logic              rst_n;
  logic              conv_done;
  logic signed [15:0] c_in [0:3][0:3];
  logic signed [15:0] bias;
  logic [3:0]        shift;
  logic signed [7:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              drop_err;

  conv_relu_pool #(.IN_W(16), .OUT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .conv_done (conv_done),
    .c_in      (c_in),
    .bias      (bias),
    .shift     (shift),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  int beats[$];
  int last_mask;
  int first_valid;
  int stall_bad;
  int busy_after;

  // Reference: each output is the max over its 2x2 window of the requantised elements.
  function automatic int model_beat(input int k);
    int best, s;
    best = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (i / 2 == k / 2 && j / 2 == k % 2) begin
          s = int'(c_in[i][j]) + int'(bias);
          if (s < 0) s = 0;
          if (shift != 0) s = s + (1 << (int'(shift) - 1));
          s = s >> shift;
          if (s > 127) s = 127;
          if (s > best) best = s;
        end
      end
    end
    return best;
  endfunction

  task automatic set_pattern_tile();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) c_in[i][j] = 16'(9 * (i + j) + 18);
  endtask

  // Starts a tile at the current negedge and records every handshake for `budget` cycles.
  // rmode: 0 ready high, 1 toggle, 2 random. pulse_at re-raises conv_done for one cycle.
  task automatic run_tile(input int hold, input int rmode, input int pulse_at, input int budget);
    bit prev_stall, pend, pl;
    int pd;
    beats.delete();
    last_mask = 0; first_valid = -1; stall_bad = 0; busy_after = -1;
    prev_stall = 0; pend = 0; pd = 0; pl = 0;
    conv_done = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (cyc == pulse_at) conv_done = 1'b1;
      else if (cyc >= hold) conv_done = 1'b0;
      if (pend) begin busy_after = int'(busy); pend = 0; end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!out_valid || int'(out_data) != pd || out_last != pl)) stall_bad++;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      prev_stall = out_valid && !out_ready;
      pd = int'(out_data);
      pl = out_last;
      if (out_valid && out_ready) begin
        if (out_last) begin
          last_mask |= (1 << beats.size());
          pend = 1;
        end
        beats.push_back(int'(out_data));
      end
    end
    out_ready = 1'b0;
    conv_done = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, out_last, busy, drop_err, out_data} !== 12'h0)
      $display("FAIL reset_async got v=%b l=%b b=%b e=%b d=%0d want all 0",
               out_valid, out_last, busy, drop_err, out_data);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({out_valid, out_last, busy, drop_err, out_data} !== 12'h0)
      $display("FAIL reset_idle got v=%b l=%b b=%b e=%b d=%0d want all 0",
               out_valid, out_last, busy, drop_err, out_data);
    else n_pass++;
  endtask

  task automatic test_basic();
    int want [4] = '{36, 54, 54, 72};
    set_pattern_tile(); bias = 0; shift = 0;
    run_tile(1, 0, -1, 12);
    n_total++;
    if (beats.size() != 4) $display("FAIL basic_count got %0d want 4", beats.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (i >= beats.size() || beats[i] != want[i])
        $display("FAIL basic_beat%0d got %0d want %0d", i, (i < beats.size()) ? beats[i] : -1,
                 want[i]);
      else n_pass++;
    end
    n_total++;
    if (last_mask != 8) $display("FAIL basic_last got mask %0d want 8", last_mask);
    else n_pass++;
    n_total++;
    if (first_valid != 5) $display("FAIL basic_latency got %0d want 5", first_valid);
    else n_pass++;
    n_total++;
    if (busy_after != 0) $display("FAIL basic_busy_drop got %0d want 0", busy_after);
    else n_pass++;
  endtask

  task automatic test_shift();
    int want [4] = '{9, 14, 14, 18};
    set_pattern_tile(); bias = 0; shift = 4'd2;
    run_tile(1, 0, -1, 12);
    n_total++;
    if (beats.size() != 4) $display("FAIL shift_count got %0d want 4", beats.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      n_total++;
      if (beats[i] != want[i]) $display("FAIL shift_beat%0d got %0d want %0d", i, beats[i], want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    int want_sat [2] = '{127, 0};
    int bias_v   [2] = '{1000, -100};
    for (int t = 0; t < 2; t++) begin
      set_pattern_tile(); bias = 16'(bias_v[t]); shift = 0;
      run_tile(1, 0, -1, 12);
      n_total++;
      if (beats.size() != 4) $display("FAIL sat%0d_count got %0d want 4", t, beats.size());
      else n_pass++;
      for (int i = 0; i < beats.size(); i++) begin
        n_total++;
        if (beats[i] != want_sat[t])
          $display("FAIL sat%0d_beat%0d got %0d want %0d", t, i, beats[i], want_sat[t]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_no_wrap();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) c_in[i][j] = 16'sh7fff;
    bias = 16'sh7fff; shift = 4'd15;
    run_tile(1, 0, -1, 12);
    n_total++;
    if (beats.size() != 4) $display("FAIL nowrap_count got %0d want 4", beats.size());
    else n_pass++;
    for (int i = 0; i < beats.size(); i++) begin
      n_total++;
      if (beats[i] != 2) $display("FAIL nowrap_beat%0d got %0d want 2", i, beats[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int want [4] = '{36, 54, 54, 72};
    set_pattern_tile(); bias = 0; shift = 0;
    run_tile(1, 1, -1, 20);
    n_total++;
    if (beats.size() != 4) $display("FAIL bp_count got %0d want 4", beats.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      n_total++;
      if (beats[i] != want[i]) $display("FAIL bp_beat%0d got %0d want %0d", i, beats[i], want[i]);
      else n_pass++;
    end
    n_total++;
    if (stall_bad != 0) $display("FAIL bp_stable got %0d unstable stalls want 0", stall_bad);
    else n_pass++;
    n_total++;
    if (busy_after != 0) $display("FAIL bp_busy_drop got %0d want 0", busy_after);
    else n_pass++;
    n_total++;
    if (last_mask != 8) $display("FAIL bp_last got mask %0d want 8", last_mask);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int want [4];
    set_pattern_tile(); bias = 0; shift = 0;
    run_tile(1, 0, -1, 9);
    n_total++;
    if (beats.size() != 4 || busy_after != 0)
      $display("FAIL b2b_first got %0d beats busy %0d want 4 beats busy 0", beats.size(),
               busy_after);
    else n_pass++;
    // Next tile captured on the edge right after the previous one finishes.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) c_in[i][j] = 16'(5 * i * j + 3 * i);
    bias = 16'(7); shift = 4'd1;
    for (int k = 0; k < 4; k++) want[k] = model_beat(k);
    run_tile(1, 0, -1, 12);
    n_total++;
    if (first_valid != 5) $display("FAIL b2b_latency got %0d want 5", first_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (i >= beats.size() || beats[i] != want[i])
        $display("FAIL b2b_beat%0d got %0d want %0d", i, (i < beats.size()) ? beats[i] : -1,
                 want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_level_hold();
    set_pattern_tile(); bias = 0; shift = 0;
    run_tile(20, 0, -1, 30);
    n_total++;
    if (beats.size() != 4) $display("FAIL level_count got %0d want 4", beats.size());
    else n_pass++;
    n_total++;
    if (drop_err !== 1'b0) $display("FAIL level_drop_err got %b want 0", drop_err);
    else n_pass++;
  endtask

  task automatic test_random();
    int want [4];
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          c_in[i][j] = (t % 2 == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 2000)) - 500);
      bias  = (t % 2 == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 400)) - 200);
      shift = (t % 2 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      for (int k = 0; k < 4; k++) want[k] = model_beat(k);
      run_tile(1, 2, -1, 50);
      n_total++;
      if (beats.size() != 4 || stall_bad != 0 || last_mask != 8)
        $display("FAIL rand%0d_proto got %0d beats %0d unstable lastmask %0d want 4/0/8", t,
                 beats.size(), stall_bad, last_mask);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (i >= beats.size() || beats[i] != want[i])
          $display("FAIL rand%0d_beat%0d got %0d want %0d", t, i,
                   (i < beats.size()) ? beats[i] : -1, want[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_drop_final();
    set_pattern_tile(); bias = 0; shift = 0;
    run_tile(1, 0, 8, 25);
    n_total++;
    if (beats.size() != 4) $display("FAIL dropfinal_count got %0d want 4", beats.size());
    else n_pass++;
    n_total++;
    if (drop_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL dropfinal_state got err=%b busy=%b want err=1 busy=0", drop_err, busy);
    else n_pass++;
  endtask

  task automatic test_drop_stream();
    int want [4] = '{36, 54, 54, 72};
    set_pattern_tile(); bias = 0; shift = 0;
    run_tile(1, 1, 6, 25);
    n_total++;
    if (beats.size() != 4) $display("FAIL dropstream_count got %0d want 4", beats.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      n_total++;
      if (beats[i] != want[i])
        $display("FAIL dropstream_beat%0d got %0d want %0d", i, beats[i], want[i]);
      else n_pass++;
    end
    n_total++;
    if (drop_err !== 1'b1) $display("FAIL dropstream_err got %b want 1", drop_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    set_pattern_tile(); bias = 0; shift = 0;
    out_ready = 1'b0;
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    repeat (5) @(negedge clk);
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 8'sd36)
      $display("FAIL midrst_pre got v=%b d=%0d want v=1 d=36", out_valid, out_data);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, out_last, busy, drop_err, out_data} !== 12'h0)
      $display("FAIL midrst_outputs got v=%b l=%b b=%b e=%b d=%0d want all 0",
               out_valid, out_last, busy, drop_err, out_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b1; conv_done = 1'b0; out_ready = 1'b0;
    bias = '0; shift = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) c_in[i][j] = '0;
    test_reset();
    test_basic();
    test_shift();
    test_saturate();
    test_no_wrap();
    test_backpressure();
    test_back_to_back();
    test_level_hold();
    test_random();
    test_drop_final();
    test_drop_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conv_relu_pool.md
# conv_relu_pool

Post-processing stage directly downstream of `matrix_convolution`. It captures the 4×4 signed convolution result `c` when the convolver signals done, then applies per-tile bias, ReLU, rounded right-shift requantisation with saturation, and 2×2 max-pooling. The resulting 2×2 tile is streamed out as four int8 beats on a valid/ready interface toward the tile write-back path.

## Interface
- `IN_W`, 16, width of each convolution result element (signed)
- `OUT_W`, 8, width of each output element (signed); saturation ceiling is 2^(OUT_W-1)-1
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `conv_done`  in  1  done from convolver; level or pulse, rising edge used
- `c_in[0:3][0:3]`  in  IN_W signed each  convolution tile; valid while `conv_done` high
- `bias`  in  IN_W signed  added to every element; sampled at capture
- `shift`  in  4  requantisation right-shift amount, 0..15; sampled at capture
- `out_data`  out  OUT_W signed  pooled element
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  downstream accepts; beat transfers on `out_valid && out_ready` at a rising edge
- `out_last`  out  1  high with the 4th (final) beat of a tile
- `busy`  out  1  high whenever state ≠ IDLE
- `drop_err`  out  1  sticky; a tile arrived while busy and was dropped

## Operation
- Edge detect: `done_q` registers `conv_done`; capture event = `conv_done && !done_q`.
- FSM states: IDLE → PROC → STREAM → IDLE.
- IDLE: on capture event, register all 16 `c_in` elements, `bias`, `shift`; k←0; go PROC.
- PROC: one pooling window per cycle, k=0..3; result written to `res[k]`; after k=3 go STREAM, beat index←0.
- Windows (row,col): k0 rows0-1 cols0-1; k1 rows0-1 cols2-3; k2 rows2-3 cols0-1; k3 rows2-3 cols2-3.
- Per element: s = c + bias, IN_W+1 bits signed (no wrap); r = max(s,0); q = (r + (shift ? 2^(shift-1) : 0)) >> shift, computed at IN_W+2 bits; y = min(q, 2^(OUT_W-1)-1).
- Window result = max of its four y values; always in 0..2^(OUT_W-1)-1.
- STREAM: `out_valid`=1, `out_data`=res[index]; index advances on handshake; `out_last`=1 when index=3; handshake at index 3 → IDLE.
- Capture event in PROC or STREAM: tile ignored; `drop_err`←1 (cleared only by reset). Captured data is never overwritten mid-tile.
- `out_data`/`out_last` held stable while `out_valid && !out_ready`.

## Timing
- Reset (async, any state): state IDLE, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `drop_err`=0, `done_q`=0, res/tile regs 0.
- If `conv_done` is high when reset releases, the first edge sees a rising edge and captures; this is intended.
- Edge E0 samples capture event → `busy` high after E0.
- E1..E4 compute res[0..3]; `out_valid` high after E4.
- With `out_ready` held high, beats transfer at E5..E8; after E8 `out_valid`=0, `busy`=0. Minimum tile period is 9 cycles.
- A capture event at the same edge as the final handshake (E8) is dropped: the state is still STREAM at that edge.
- Backpressure stalls only STREAM and extends `busy` one cycle per stalled cycle. It has no effect on PROC.
- `out_ready` is ignored while `out_valid`=0.

## Test plan
- Tile c[i][j]=9(i+j)+18, bias 0, shift 0, ready high → beats 36,54,54,72; `out_last` on 72; first `out_valid` 5 cycles after capture edge.
- Same tile, shift 2 → beats 9,14,14,18. The rounding gives 38>>2=9, 56>>2=14, 74>>2=18.
- Same tile with bias 1000 → four beats of 127 (saturation). With bias -100 → four beats of 0 (ReLU).
- All c=32767, bias 32767, shift 15 → four beats of 2. This checks there is no 16-bit wrap: (65534+16384)>>15=2.
- Backpressure: toggle `out_ready` 0/1 every cycle → 4 beats, order 36,54,54,72, data stable while stalled, `busy` drops one cycle after last handshake.
- Hold `conv_done` level-high for 20 cycles → exactly one tile streamed, `drop_err` stays 0. Then pulse `conv_done` during STREAM → no extra beats, `drop_err`=1. Assert `rst_n`=0 mid-STREAM → all outputs 0 immediately.
